// File: rtl/cpu_clock_controller.sv
// cpu_clock_controller: CPU clock-enable generator with halt, run, divided-run and debounced single-step modes
module cpu_clock_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 fast_clock,
    input  logic                 reset,
    input  logic [1:0]           mode,
    input  logic [4:0]           div_exp,
    input  logic                 step_btn,
    input  logic                 halt_req,
    input  logic                 clear_halt,
    output logic                 cpu_clk_en,
    output logic [CNT_WIDTH-1:0] tick_count,
    output logic [2:0]           state,
    output logic [3:0]           ledr
);
    typedef enum logic [2:0] {IDLE = 3'd0, RUN = 3'd1, DIV = 3'd2, STEP = 3'd3, HALTED = 3'd4} state_t;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    state_t st, st_next, mode_st;
    logic [1:0] mode_s1, mode_s2;
    logic [4:0] div_s1, div_s2;
    logic btn_s1, btn_s2, cand, deb, deb_prev, deb_done, en_next;
    logic [DW-1:0] deb_cnt;
    logic [CNT_WIDTH-1:0] count, lim;
    always_ff @(posedge fast_clock or posedge reset) begin
        if (reset) begin
            mode_s1 <= '0;
            mode_s2 <= '0;
            div_s1 <= '0;
            div_s2 <= '0;
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
        end else begin
            mode_s1 <= mode;
            mode_s2 <= mode_s1;
            div_s1 <= div_exp;
            div_s2 <= div_s1;
            btn_s1 <= step_btn;
            btn_s2 <= btn_s1;
        end
    end
    always_ff @(posedge fast_clock or posedge reset) begin
        if (reset)
            st <= IDLE;
        else
            st <= st_next;
    end
    // halt_req dominates both the transition and the enable so nothing leaks past a halt
    always_comb begin
        mode_st = state_t'({1'b0, mode_s2});
        st_next = halt_req ? HALTED : (st == HALTED && !clear_halt) ? HALTED : mode_st;
        lim = (CNT_WIDTH'(1) << div_s2) - CNT_WIDTH'(1);
        deb_done = (btn_s2 == cand) && (deb_cnt == DW'(DEBOUNCE_CYCLES - 1));
        en_next = !halt_req && (st == RUN || (st == DIV && count >= lim) || (st == STEP && deb && !deb_prev));
    end
    always_ff @(posedge fast_clock or posedge reset) begin
        if (reset) begin
            count <= '0;
            cand <= 1'b0;
            deb <= 1'b0;
            deb_prev <= 1'b0;
            deb_cnt <= '0;
            cpu_clk_en <= 1'b0;
            tick_count <= '0;
        end else begin
            count <= (st != DIV || count >= lim) ? '0 : count + CNT_WIDTH'(1);
            cand <= btn_s2;
            deb_cnt <= (btn_s2 != cand) ? '0 : deb_done ? deb_cnt : deb_cnt + DW'(1);
            deb <= deb_done ? cand : deb;
            deb_prev <= deb;
            cpu_clk_en <= en_next;
            tick_count <= tick_count + CNT_WIDTH'(cpu_clk_en);
        end
    end
    assign state = st;
    assign ledr = {st == HALTED, st};
endmodule

// File: tb/tb_cpu_clock_controller.sv
// tb_cpu_clock_controller: table-driven and sequence checks of the CPU clock-enable controller
module tb_cpu_clock_controller;
    localparam int CW = 32;
    logic fast_clock = 1'b0, reset = 1'b1;
    logic [1:0] mode = 2'd0;
    logic [4:0] div_exp = 5'd0;
    logic step_btn = 1'b0, halt_req = 1'b0, clear_halt = 1'b0;
    logic cpu_clk_en;
    logic [CW-1:0] tick_count;
    logic [2:0] state;
    logic [3:0] ledr;
    int vectors = 0, miscompares = 0;

    typedef struct {logic [1:0] mode; logic halt; logic clear; logic [2:0] st; logic en; int tick;} vec_t;
    typedef struct {string name; logic full; logic [2:0] st; logic en; int tick;} exp_t;
    vec_t tbl[$];
    exp_t sb[$];

    cpu_clock_controller #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(CW)) dut (
        .fast_clock(fast_clock), .reset(reset), .mode(mode), .div_exp(div_exp),
        .step_btn(step_btn), .halt_req(halt_req), .clear_halt(clear_halt),
        .cpu_clk_en(cpu_clk_en), .tick_count(tick_count), .state(state), .ledr(ledr)
    );

    always #5 fast_clock = ~fast_clock;

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    function automatic void add(input logic [1:0] m, input logic h, input logic c, input logic [2:0] s, input logic e, input int t);
        vec_t v;
        v.mode = m; v.halt = h; v.clear = c; v.st = s; v.en = e; v.tick = t;
        tbl.push_back(v);
    endfunction

    // expectation queued as inputs are driven, retired after the next edge
    task automatic cycle(input string name, input logic full, input logic [2:0] st, input logic en, input int tick);
        exp_t e;
        e.name = name; e.full = full; e.st = st; e.en = en; e.tick = tick;
        sb.push_back(e);
        @(posedge fast_clock);
        @(negedge fast_clock);
        e = sb.pop_front();
        check({e.name, " en"}, 64'(cpu_clk_en), 64'(e.en));
        if (e.full) begin
            check({e.name, " state"}, 64'(state), 64'(e.st));
            check({e.name, " tick"}, 64'(tick_count), 64'(e.tick));
            check({e.name, " ledr"}, 64'(ledr), 64'({e.st == 3'd4, e.st}));
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge fast_clock);
            @(negedge fast_clock);
        end
    endtask

    task automatic count_en(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(posedge fast_clock);
            @(negedge fast_clock);
            c += int'(cpu_clk_en);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input string name);
        for (int i = 0; i < 10 && state != s; i++) run(1);
        check(name, 64'(state), 64'(s));
    endtask

    task automatic press(input int len, input int tail, output int n);
        int a, b;
        step_btn = 1'b1;
        count_en(len, a);
        step_btn = 1'b0;
        count_en(tail, b);
        n = a + b;
    endtask

    initial begin
        int n, a, b, found;
        add(1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0);
        add(1, 0, 0, 1, 1, 0);
        for (int k = 1; k <= 10; k++) add(1, 0, 0, 1, 1, k);
        add(1, 1, 0, 4, 0, 11);
        add(0, 0, 0, 4, 0, 11);
        add(2, 0, 0, 4, 0, 11);
        add(3, 0, 0, 4, 0, 11);
        add(1, 0, 0, 4, 0, 11);
        add(1, 0, 0, 4, 0, 11);
        add(1, 0, 1, 1, 0, 11);
        add(1, 0, 0, 1, 1, 11);
        add(1, 0, 0, 1, 1, 12);
        add(1, 1, 1, 4, 0, 13);
        add(1, 0, 0, 4, 0, 13);
        add(1, 0, 0, 4, 0, 13);
        add(1, 0, 1, 1, 0, 13);

        mode = 2'd1;
        repeat (2) @(negedge fast_clock);
        check("reset en", 64'(cpu_clk_en), 64'd0);
        check("reset tick", 64'(tick_count), 64'd0);
        check("reset state", 64'(state), 64'd0);
        check("reset ledr", 64'(ledr), 64'd0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            mode = tbl[i].mode;
            halt_req = tbl[i].halt;
            clear_halt = tbl[i].clear;
            cycle($sformatf("vec%0d", i), 1'b1, tbl[i].st, tbl[i].en, tbl[i].tick);
        end
        halt_req = 1'b0;
        clear_halt = 1'b0;

        mode = 2'd2;
        div_exp = 5'd3;
        wait_state(3'd2, "enter_div");
        for (int k = 1; k <= 24; k++) cycle($sformatf("div8_%0d", k), 1'b0, 3'd0, k % 8 == 0, 0);
        div_exp = 5'd0;
        run(3);
        for (int k = 1; k <= 8; k++) cycle($sformatf("div1_%0d", k), 1'b0, 3'd0, 1'b1, 0);

        div_exp = 5'd10;
        run(4);
        count_en(496, n);
        check("div1024_quiet", 64'(n), 64'd0);
        div_exp = 5'd2;
        found = 0;
        for (int k = 1; k <= 3; k++) begin
            run(1);
            if (cpu_clk_en && found == 0) found = k;
        end
        check("div_lower_fire", 64'(found >= 1 && found <= 3), 64'd1);
        for (int k = 1; k <= 12; k++) cycle($sformatf("div4_%0d", k), 1'b0, 3'd0, k % 4 == 0, 0);

        mode = 2'd3;
        wait_state(3'd3, "enter_step");
        press(1, 1, a);
        press(1, 1, b);
        press(10, 10, n);
        check("step_bounce_hold", 64'(a + b + n), 64'd1);
        press(10, 10, n);
        check("step_second", 64'(n), 64'd1);
        press(3, 10, n);
        check("step_short", 64'(n), 64'd0);

        mode = 2'd1;
        wait_state(3'd1, "enter_run_held");
        step_btn = 1'b1;
        run(10);
        mode = 2'd3;
        wait_state(3'd3, "enter_step_held");
        count_en(10, n);
        check("step_entry_held", 64'(n), 64'd0);
        step_btn = 1'b0;
        run(10);
        mode = 2'd1;
        wait_state(3'd1, "enter_run_press");
        press(10, 10, n);
        mode = 2'd3;
        wait_state(3'd3, "enter_step_again");
        count_en(10, n);
        check("step_no_queue", 64'(n), 64'd0);
        press(10, 10, n);
        check("step_after_queue", 64'(n), 64'd1);

        mode = 2'd2;
        div_exp = 5'd0;
        wait_state(3'd2, "enter_div_reset");
        run(5);
        check("pre_reset_en", 64'(cpu_clk_en), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("async_reset en", 64'(cpu_clk_en), 64'd0);
        check("async_reset tick", 64'(tick_count), 64'd0);
        check("async_reset state", 64'(state), 64'd0);
        @(negedge fast_clock);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
